seven_segment_capture: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment driver. It samples a time-multiplexed segment bus (8 segment lines incl. DP plus one-hot digit selects), de-glitches it, and decodes each lit digit's segment pattern back into the 6-bit per-digit code `{enable, dp, hex[3:0]}`. It sits on FPGA pins observing an external display, or in loopback benches checking driver output, and presents a register per digit to downstream logic.

---
 rtl/seven_segment_capture.sv | 176 +++++++++++++++++
 tb/tb_seven_segment_capture.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed seven-segment bus, de-glitches it and decodes each lit digit back to {enable, dp, hex}.
// Optional per-digit refresh timeout: define SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN.
module seven_segment_capture #(
   parameter int   NUMBER_OF_DIGITS = 4,
   parameter logic CATHODE_COMMON   = 1'b1,
   parameter int   STABLE_CYCLES    = 4,
   parameter int   TIMEOUT_CYCLES   = 65536
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [7:0]                  segment_in,
   input  logic [NUMBER_OF_DIGITS-1:0] digit_selector_in,
   input  logic                        clear,
   output logic [5:0]                  digits [0:NUMBER_OF_DIGITS-1],
   output logic [NUMBER_OF_DIGITS-1:0] digit_valid,
   output logic [NUMBER_OF_DIGITS-1:0] pattern_error,
   output logic                        update
);

   localparam int NUMBER_OF_SEGMENTS = 8;
   localparam int RUN_W = $clog2(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_ARM  = RUN_W'(STABLE_CYCLES - 2);

   if (NUMBER_OF_DIGITS < 1 || NUMBER_OF_DIGITS > 16) begin : g_bad_digit_count
      $error("seven_segment_capture: NUMBER_OF_DIGITS must be 1..16");
   end
   if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
      $error("seven_segment_capture: STABLE_CYCLES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
      $error("seven_segment_capture: TIMEOUT_CYCLES must be at least 1");
   end

   // Map the segment pattern (bit0=a .. bit6=g) to {hit, hex}; hit=0 for anything outside the font.
   function automatic logic [4:0] decode_hex(input logic [6:0] seg);
      logic [4:0] result;
      case (seg)
         7'h3F:   result = {1'b1, 4'h0};
         7'h06:   result = {1'b1, 4'h1};
         7'h5B:   result = {1'b1, 4'h2};
         7'h4F:   result = {1'b1, 4'h3};
         7'h66:   result = {1'b1, 4'h4};
         7'h6D:   result = {1'b1, 4'h5};
         7'h7D:   result = {1'b1, 4'h6};
         7'h07:   result = {1'b1, 4'h7};
         7'h7F:   result = {1'b1, 4'h8};
         7'h6F:   result = {1'b1, 4'h9};
         7'h77:   result = {1'b1, 4'hA};
         7'h7C:   result = {1'b1, 4'hB};
         7'h39:   result = {1'b1, 4'hC};
         7'h5E:   result = {1'b1, 4'hD};
         7'h79:   result = {1'b1, 4'hE};
         7'h71:   result = {1'b1, 4'hF};
         default: result = 5'b0;
      endcase
      return result;
   endfunction

   logic [NUMBER_OF_SEGMENTS-1:0] seg_norm, seg_meta, seg_sync, seg_prev;
   logic [NUMBER_OF_DIGITS-1:0]   sel_norm, sel_meta, sel_sync, sel_prev;
   logic [RUN_W-1:0]              run;
   logic                          stable;
   logic                          capture;
   logic [NUMBER_OF_DIGITS-1:0]   write_en;
   logic [4:0]                    decoded;
   logic                          blank;

   // Everything downstream of here works in active-high terms.
   assign seg_norm = CATHODE_COMMON ? segment_in : ~segment_in;
   assign sel_norm = CATHODE_COMMON ? ~digit_selector_in : digit_selector_in;

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_meta <= '0;
         seg_sync <= '0;
         sel_meta <= '0;
         sel_sync <= '0;
      end else begin
         seg_meta <= seg_norm;
         seg_sync <= seg_meta;
         sel_meta <= sel_norm;
         sel_sync <= sel_meta;
      end
   end

   assign stable  = (seg_sync == seg_prev) && (sel_sync == sel_prev);
   assign capture = stable && (run == RUN_ARM);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_prev <= '0;
         sel_prev <= '0;
         run      <= '0;
      end else begin
         seg_prev <= seg_sync;
         sel_prev <= sel_sync;
         if (clear || !stable) begin
            run <= '0;
         end else if (run != RUN_LAST) begin
            run <= run + 1'b1;
         end
      end
   end

   // NOTE: defaults come first in always_comb so no path leaves a signal unassigned (no latches).
   always_comb begin
      write_en = '0;
      if (capture && $onehot(sel_sync)) begin
         write_en = sel_sync;
      end
      decoded = decode_hex(seg_sync[6:0]);
      blank   = (seg_sync[6:0] == 7'h00) && !seg_sync[7];
   end

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_ARM = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_W-1:0] refresh [0:NUMBER_OF_DIGITS-1];
`endif

   // NOTE: the per-digit register file is reset like ordinary flops; it is small and consumers need known values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
            digits[d] <= '0;
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
            refresh[d] <= '0;
`endif
         end
         digit_valid   <= '0;
         pattern_error <= '0;
         update        <= 1'b0;
      end else if (clear) begin
         for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
            digits[d] <= '0;
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
            refresh[d] <= '0;
`endif
         end
         digit_valid   <= '0;
         pattern_error <= '0;
         update        <= 1'b0;
      end else begin
         update <= |write_en;
         for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
            if (write_en[d]) begin
               digit_valid[d] <= 1'b1;
               if (blank) begin
                  digits[d]        <= '0;
                  pattern_error[d] <= 1'b0;
               end else if (decoded[4]) begin
                  digits[d]        <= {1'b1, seg_sync[7], decoded[3:0]};
                  pattern_error[d] <= 1'b0;
               end else begin
                  // Undecodable: keep the last good value, flag the error.
                  pattern_error[d] <= 1'b1;
               end
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
               refresh[d] <= '0;
            end else if (refresh[d] == TIMEOUT_ARM) begin
               refresh[d]       <= TIMEOUT_MAX;
               digits[d]        <= '0;
               digit_valid[d]   <= 1'b0;
               pattern_error[d] <= 1'b0;
            end else if (refresh[d] != TIMEOUT_MAX) begin
               refresh[d] <= refresh[d] + 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed self-checking bench for seven_segment_capture (4 digits, common cathode, STABLE_CYCLES=4).
// Define SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN for both files to exercise the refresh timeout.
module tb_seven_segment_capture;

   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] segment_in = 8'h00;
   logic [N-1:0] digit_selector_in = '1;
   logic       clear = 1'b0;
   logic [5:0] digits [0:N-1];
   logic [N-1:0] digit_valid;
   logic [N-1:0] pattern_error;
   logic       update;

   int check_count = 0;
   int pass_count  = 0;

   seven_segment_capture #(
      .NUMBER_OF_DIGITS(N),
      .CATHODE_COMMON(1'b1),
      .STABLE_CYCLES(4),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .segment_in(segment_in),
      .digit_selector_in(digit_selector_in),
      .clear(clear),
      .digits(digits),
      .digit_valid(digit_valid),
      .pattern_error(pattern_error),
      .update(update)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // d < 0 deselects every digit; selects are active-low on a common-cathode bus.
   task automatic drive(input int d, input logic [7:0] seg);
      logic [N-1:0] one;
      one = 4'b0001;
      digit_selector_in = (d < 0) ? '1 : ~(one << d);
      segment_in = seg;
   endtask

   task automatic run_count(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         tick(1);
         if (update === 1'b1) pulses++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      tick(3);
      for (int d = 0; d < N; d++) begin
         check_count++;
         if (digits[d] !== 6'b0) $display("FAIL reset_digit%0d got %b want 000000", d, digits[d]);
         else pass_count++;
      end
      check_count++;
      if (digit_valid !== 4'b0) $display("FAIL reset_valid got %b want 0000", digit_valid);
      else pass_count++;
      check_count++;
      if (pattern_error !== 4'b0) $display("FAIL reset_error got %b want 0000", pattern_error);
      else pass_count++;
      check_count++;
      if (update !== 1'b0) $display("FAIL reset_update got %b want 0", update);
      else pass_count++;
      reset = 1'b1;
      tick(2);
   endtask

   task automatic test_latency();
      int pulses, first;
      do_clear();
      drive(2, 8'h5B);
      pulses = 0;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (update === 1'b1) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      check_count++;
      if (pulses !== 1) $display("FAIL latency_pulses got %0d want 1", pulses);
      else pass_count++;
      check_count++;
      if (first !== 6) $display("FAIL latency_cycle got %0d want 6", first);
      else pass_count++;
      check_count++;
      if (digits[2] !== 6'b100010) $display("FAIL latency_digit2 got %b want 100010", digits[2]);
      else pass_count++;
      check_count++;
      if (digit_valid !== 4'b0100) $display("FAIL latency_valid got %b want 0100", digit_valid);
      else pass_count++;
      drive(-1, 8'h00);
      tick(8);
   endtask

   task automatic test_scan();
      int pulses, total;
      logic [7:0] codes [0:3];
      logic [5:0] want [0:3];
      codes = '{8'hBF, 8'h06, 8'h00, 8'h71};
      want  = '{6'b110000, 6'b100001, 6'b000000, 6'b101111};
      do_clear();
      total = 0;
      for (int d = 0; d < N; d++) begin
         drive(d, codes[d]);
         run_count(10, pulses);
         total += pulses;
      end
      drive(-1, 8'h00);
      tick(8);
      for (int d = 0; d < N; d++) begin
         check_count++;
         if (digits[d] !== want[d]) $display("FAIL scan_digit%0d got %b want %b", d, digits[d], want[d]);
         else pass_count++;
      end
      check_count++;
      if (pattern_error !== 4'b0) $display("FAIL scan_error got %b want 0000", pattern_error);
      else pass_count++;
      check_count++;
      if (digit_valid !== 4'b1111) $display("FAIL scan_valid got %b want 1111", digit_valid);
      else pass_count++;
      check_count++;
      if (total !== 4) $display("FAIL scan_pulses got %0d want 4", total);
      else pass_count++;
   endtask

   task automatic test_decode_table();
      logic [6:0] font [0:15];
      font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      do_clear();
      for (int h = 0; h < 16; h++) begin
         drive(0, {1'b0, font[h]});
         tick(8);
         check_count++;
         if (digits[0] !== {2'b10, 4'(h)})
            $display("FAIL decode_%0h got %b want %b", h, digits[0], {2'b10, 4'(h)});
         else pass_count++;
      end
      drive(-1, 8'h00);
      tick(8);
   endtask

   task automatic test_pattern_error();
      int pulses;
      do_clear();
      drive(0, 8'h06);
      tick(10);
      drive(0, 8'h2A);
      run_count(10, pulses);
      check_count++;
      if (pattern_error !== 4'b0001) $display("FAIL err_flag got %b want 0001", pattern_error);
      else pass_count++;
      check_count++;
      if (digits[0] !== 6'b100001) $display("FAIL err_hold got %b want 100001", digits[0]);
      else pass_count++;
      check_count++;
      if (pulses !== 1) $display("FAIL err_pulses got %0d want 1", pulses);
      else pass_count++;
      drive(0, 8'h4F);
      tick(10);
      check_count++;
      if (pattern_error !== 4'b0000) $display("FAIL err_recover got %b want 0000", pattern_error);
      else pass_count++;
      drive(0, 8'h80);
      tick(10);
      check_count++;
      if (pattern_error !== 4'b0001 || digits[0] !== 6'b100011)
         $display("FAIL err_blank_dp got err=%b dig=%b want err=0001 dig=100011", pattern_error, digits[0]);
      else pass_count++;
      drive(-1, 8'h00);
      tick(8);
   endtask

   task automatic test_no_write();
      int pulses, total;
      do_clear();
      total = 0;
      digit_selector_in = 4'b1100;
      segment_in = 8'h06;
      run_count(10, pulses);
      total += pulses;
      drive(-1, 8'h06);
      run_count(10, pulses);
      total += pulses;
      drive(1, 8'h06);
      run_count(3, pulses);
      total += pulses;
      drive(-1, 8'h00);
      run_count(10, pulses);
      total += pulses;
      check_count++;
      if (total !== 0) $display("FAIL nowrite_pulses got %0d want 0", total);
      else pass_count++;
      check_count++;
      if (digit_valid !== 4'b0000) $display("FAIL nowrite_valid got %b want 0000", digit_valid);
      else pass_count++;
      // A 3-cycle segment glitch on a lit digit must not land.
      drive(1, 8'h06);
      run_count(10, pulses);
      total = pulses;
      drive(1, 8'h4F);
      run_count(3, pulses);
      total += pulses;
      drive(1, 8'h06);
      run_count(10, pulses);
      total += pulses;
      check_count++;
      if (total !== 2) $display("FAIL glitch_pulses got %0d want 2", total);
      else pass_count++;
      check_count++;
      if (digits[1] !== 6'b100001) $display("FAIL glitch_digit1 got %b want 100001", digits[1]);
      else pass_count++;
      // Exactly STABLE_CYCLES of hold is enough.
      drive(3, 8'h7F);
      tick(4);
      drive(-1, 8'h00);
      tick(8);
      check_count++;
      if (digits[3] !== 6'b101000 || digit_valid[3] !== 1'b1)
         $display("FAIL min_hold got dig=%b valid=%b want dig=101000 valid=1", digits[3], digit_valid[3]);
      else pass_count++;
   endtask

   task automatic test_clear_collision();
      do_clear();
      drive(3, 8'h71);
      tick(8);
      drive(0, 8'h06);
      tick(5);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      drive(-1, 8'h00);
      check_count++;
      if (digits[0] !== 6'b0 || digits[3] !== 6'b0)
         $display("FAIL clr_digits got d0=%b d3=%b want 000000", digits[0], digits[3]);
      else pass_count++;
      check_count++;
      if (digit_valid !== 4'b0 || pattern_error !== 4'b0 || update !== 1'b0)
         $display("FAIL clr_flags got valid=%b err=%b upd=%b want 0", digit_valid, pattern_error, update);
      else pass_count++;
      tick(10);
   endtask

   task automatic test_mid_reset();
      do_clear();
      drive(1, 8'h06);
      tick(8);
      drive(2, 8'h4F);
      tick(3);
      #2 reset = 1'b0;
      #1;
      check_count++;
      if (digit_valid !== 4'b0 || digits[1] !== 6'b0 || update !== 1'b0)
         $display("FAIL midreset got valid=%b d1=%b upd=%b want 0", digit_valid, digits[1], update);
      else pass_count++;
      drive(-1, 8'h00);
      tick(2);
      reset = 1'b1;
      tick(8);
   endtask

   task automatic test_hold();
      do_clear();
      drive(1, 8'h06);
      tick(6);
      drive(-1, 8'h00);
      check_count++;
      if (digit_valid[1] !== 1'b1) $display("FAIL hold_written got %b want 1", digit_valid[1]);
      else pass_count++;
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
      tick(99);
      check_count++;
      if (digit_valid[1] !== 1'b1) $display("FAIL timeout_early got %b want 1", digit_valid[1]);
      else pass_count++;
      tick(1);
      check_count++;
      if (digit_valid[1] !== 1'b0 || digits[1] !== 6'b0 || update !== 1'b0)
         $display("FAIL timeout_drop got valid=%b d1=%b upd=%b want 0", digit_valid[1], digits[1], update);
      else pass_count++;
`else
      tick(150);
      check_count++;
      if (digit_valid[1] !== 1'b1 || digits[1] !== 6'b100001)
         $display("FAIL hold_forever got valid=%b d1=%b want 1/100001", digit_valid[1], digits[1]);
      else pass_count++;
`endif
   endtask

   initial begin
      test_reset();
      test_latency();
      test_scan();
      test_decode_table();
      test_pattern_error();
      test_no_write();
      test_clear_collision();
      test_mid_reset();
      test_hold();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
